adder_sequencer: RTL



---
 rtl/adder_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/adder_sequencer.sv
// adder_sequencer: wide a+b+carry_in computed one WIDTH-bit slice per clock, LSB slice first.
//   Optional feature macro SUB_EN adds port sub (subtract a-b when 1, sampled at accept).
//   Ports: clk, rst_n (sync, active-low)
//          in_valid/in_ready, a, b, carry_in (, sub) : operand handshake
//          out_valid/out_ready, sum, carry_out      : result handshake
//          busy                                    : high while in RUN or DONE
module adder_sequencer #(
  parameter int WIDTH = 3,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   carry_in,
`ifdef SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   carry_out,
  output logic                   busy
);
  localparam int TW = WIDTH * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d;
  logic [TW-1:0] b_in;
  logic cin;
  logic [WIDTH-1:0] a_s, b_s, r_s;
  logic c_s;
`ifdef SUB_EN
  // Subtraction as a + ~b + 1; carry_out then reads as "no borrow".
  assign b_in = sub ? ~b : b;
  assign cin  = sub | carry_in;
`else
  assign b_in = b;
  assign cin  = carry_in;
`endif
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign sum       = sum_q;
  assign carry_out = carry_q;
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int j = 0; j < WORDS; j++)
      if (idx_q == IW'(j)) begin
        a_s = a_q[j*WIDTH +: WIDTH];
        b_s = b_q[j*WIDTH +: WIDTH];
      end
  end
  assign {c_s, r_s} = {1'b0, a_s} + {1'b0, b_s} + (WIDTH+1)'(carry_q);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b_in;
        carry_d = cin;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        for (int j = 0; j < WORDS; j++)
          if (idx_q == IW'(j)) sum_d[j*WIDTH +: WIDTH] = r_s;
        carry_d = c_s;
        idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
        state_d = idx_q == LAST ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end
endmodule
